// File: rtl/cordic_angle_calc_core.sv
// Pipelined vectoring-mode CORDIC: signed (cx,cy) vector -> quadrant index plus angle within the quadrant.
// One fold stage, seven two-iteration stages; the last also clamps and registers the outputs.
module cordic_angle_calc_core #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 17,
    parameter int ITERS = 14,
    parameter int INT_W = 22
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  cx_in,
    input  logic signed [IN_W-1:0]  cy_in,
    output logic signed [OUT_W-1:0] theta_1st_quad,
    output logic [1:0]              quadrant
);

    localparam int N_ST = ITERS / 2;
    localparam int Z_W  = 18;
    localparam logic signed [Z_W-1:0] THETA_MAX = 18'sd51471;

    function automatic logic signed [Z_W-1:0] atan_lut(input int i);
        case (i)
            0:       return 18'sd25736;
            1:       return 18'sd15193;
            2:       return 18'sd8027;
            3:       return 18'sd4075;
            4:       return 18'sd2045;
            5:       return 18'sd1024;
            6:       return 18'sd512;
            7:       return 18'sd256;
            8:       return 18'sd128;
            9:       return 18'sd64;
            10:      return 18'sd32;
            11:      return 18'sd16;
            12:      return 18'sd8;
            13:      return 18'sd4;
            default: return '0;
        endcase
    endfunction

    function automatic logic signed [INT_W-1:0] x_next(input logic signed [INT_W-1:0] x,
                                                       input logic signed [INT_W-1:0] y,
                                                       input int i);
        return y[INT_W-1] ? x - (y >>> i) : x + (y >>> i);
    endfunction

    function automatic logic signed [INT_W-1:0] y_next(input logic signed [INT_W-1:0] x,
                                                       input logic signed [INT_W-1:0] y,
                                                       input int i);
        return y[INT_W-1] ? y + (x >>> i) : y - (x >>> i);
    endfunction

    function automatic logic signed [Z_W-1:0] z_next(input logic signed [Z_W-1:0] z,
                                                     input logic signed [INT_W-1:0] y,
                                                     input int i);
        return y[INT_W-1] ? z - atan_lut(i) : z + atan_lut(i);
    endfunction

    logic signed [INT_W-1:0] x_q [0:N_ST-1];
    logic signed [INT_W-1:0] y_q [0:N_ST-1];
    logic signed [Z_W-1:0]   z_q [0:N_ST-1];
    logic [1:0]              quad_q [0:N_ST-1];
    logic                    zero_q [0:N_ST-1];
    logic                    axis_q [0:N_ST-1];

    logic signed [INT_W-1:0] x_d [1:N_ST-1];
    logic signed [INT_W-1:0] y_d [1:N_ST-1];
    logic signed [Z_W-1:0]   z_d [1:N_ST-1];

    logic signed [OUT_W-1:0] theta_q, theta_d;
    logic [1:0]              quadrant_q, quadrant_d;

    // Two guard bits below the integer LSB keep shift truncation off the angle.
    logic signed [INT_W-1:0] cx_w, cy_w, fold_x, fold_y;
    logic [1:0]              fold_quad;
    logic                    fold_zero, fold_axis;
    logic                    cx_neg, cy_neg, cx_nz, cy_nz;

    always_comb begin
        cx_w      = {{(INT_W-IN_W-2){cx_in[IN_W-1]}}, cx_in, 2'b00};
        cy_w      = {{(INT_W-IN_W-2){cy_in[IN_W-1]}}, cy_in, 2'b00};
        cx_neg    = cx_w[INT_W-1];
        cy_neg    = cy_w[INT_W-1];
        cx_nz     = |cx_w;
        cy_nz     = |cy_w;
        fold_x    = cx_w;
        fold_y    = cy_w;
        fold_quad = 2'd0;
        if ((cx_neg || !cx_nz) && !cy_neg && cy_nz) begin
            fold_x    = cy_w;
            fold_y    = -cx_w;
            fold_quad = 2'd1;
        end else if (cx_neg && (cy_neg || !cy_nz)) begin
            fold_x    = -cx_w;
            fold_y    = -cy_w;
            fold_quad = 2'd2;
        end else if (!cx_neg && cy_neg) begin
            fold_x    = -cy_w;
            fold_y    = cx_w;
            fold_quad = 2'd3;
        end
        fold_zero = !cx_nz && !cy_nz;
        fold_axis = ~|fold_y;
    end

    for (genvar s = 1; s < N_ST; s++) begin : g_iter
        logic signed [INT_W-1:0] xa, ya;
        logic signed [Z_W-1:0]   za;
        assign xa     = x_next(x_q[s-1], y_q[s-1], 2*s-2);
        assign ya     = y_next(x_q[s-1], y_q[s-1], 2*s-2);
        assign za     = z_next(z_q[s-1], y_q[s-1], 2*s-2);
        assign x_d[s] = x_next(xa, ya, 2*s-1);
        assign y_d[s] = y_next(xa, ya, 2*s-1);
        assign z_d[s] = z_next(za, ya, 2*s-1);
    end

    // Final stage only needs the angle, so x is not advanced past the second-to-last iteration.
    logic signed [INT_W-1:0] y_fin;
    logic signed [Z_W-1:0]   z_mid, z_fin;

    always_comb begin
        y_fin = y_next(x_q[N_ST-1], y_q[N_ST-1], ITERS-2);
        z_mid = z_next(z_q[N_ST-1], y_q[N_ST-1], ITERS-2);
        z_fin = z_next(z_mid, y_fin, ITERS-1);
        if (z_fin[Z_W-1]) begin
            theta_d = '0;
        end else if (z_fin > THETA_MAX) begin
            theta_d = THETA_MAX[OUT_W-1:0];
        end else begin
            theta_d = z_fin[OUT_W-1:0];
        end
        // On-axis inputs report exactly zero instead of the CORDIC residual.
        if (zero_q[N_ST-1] || axis_q[N_ST-1]) begin
            theta_d = '0;
        end
        quadrant_d = zero_q[N_ST-1] ? 2'd0 : quad_q[N_ST-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < N_ST; s++) begin
                x_q[s]    <= '0;
                y_q[s]    <= '0;
                z_q[s]    <= '0;
                quad_q[s] <= '0;
                zero_q[s] <= 1'b0;
                axis_q[s] <= 1'b0;
            end
            theta_q    <= '0;
            quadrant_q <= '0;
        end else begin
            x_q[0]    <= fold_x;
            y_q[0]    <= fold_y;
            z_q[0]    <= '0;
            quad_q[0] <= fold_quad;
            zero_q[0] <= fold_zero;
            axis_q[0] <= fold_axis;
            for (int s = 1; s < N_ST; s++) begin
                x_q[s]    <= x_d[s];
                y_q[s]    <= y_d[s];
                z_q[s]    <= z_d[s];
                quad_q[s] <= quad_q[s-1];
                zero_q[s] <= zero_q[s-1];
                axis_q[s] <= axis_q[s-1];
            end
            theta_q    <= theta_d;
            quadrant_q <= quadrant_d;
        end
    end

    assign theta_1st_quad = theta_q;
    assign quadrant       = quadrant_q;

endmodule

// File: tb/tb_cordic_angle_calc_core.sv
// Scoreboard bench for cordic_angle_calc_core: expected quadrant/angle come from real-valued atan2.
module tb_cordic_angle_calc_core;

    localparam real PI = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [15:0] cx_in = '0;
    logic signed [15:0] cy_in = '0;
    logic signed [16:0] theta_1st_quad;
    logic [1:0]         quadrant;

    cordic_angle_calc_core dut (
        .clk            (clk),
        .rst            (rst),
        .cx_in          (cx_in),
        .cy_in          (cy_in),
        .theta_1st_quad (theta_1st_quad),
        .quadrant       (quadrant)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int x;
        int y;
        int q;
        int th;
        int tol;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Full angle in [0, 2pi) split into quarter-turn index and remainder.
    function automatic void model(input int x, input int y, output int q, output int th, output int tol);
        real a, r, t;
        if (x == 0 && y == 0) begin
            q = 0; th = 0; tol = 0;
            return;
        end
        a = $atan2(real'(y), real'(x));
        if (a < 0.0) a = a + 2.0 * PI;
        r = a / (PI / 2.0) + 1.0e-12;
        q = $rtoi($floor(r));
        if (q > 3) q = 3;
        t = a - real'(q) * (PI / 2.0);
        if (t < 0.0) t = 0.0;
        th  = $rtoi($floor(t * 32768.0 + 0.5));
        tol = (x == 0 || y == 0) ? 0 : 12;
    endfunction

    task automatic send(input int x, input int y);
        exp_t e;
        @(posedge clk);
        #1;
        cx_in = 16'(x);
        cy_in = 16'(y);
        e.due = cyc + 8;
        e.x   = x;
        e.y   = y;
        model(x, y, e.q, e.th, e.tol);
        sb.push_back(e);
    endtask

    task automatic send_random();
        int x, y;
        do begin
            x = int'($urandom_range(65535)) - 32768;
            y = int'($urandom_range(65535)) - 32768;
        end while (x * x + y * y < 8192 * 8192);
        send(x, y);
    endtask

    initial begin
        exp_t e;
        int   d;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                checks++;
                if (theta_1st_quad !== 17'sd0 || quadrant !== 2'd0) begin
                    errors++;
                    $display("FAIL reset_out: got theta=%0d q=%0d, want theta=0 q=0", theta_1st_quad, quadrant);
                end
            end else begin
                while (sb.size() > 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    checks++;
                    d = int'(theta_1st_quad) - e.th;
                    if (d < 0) d = -d;
                    if (e.due != cyc || quadrant !== 2'(e.q) || d > e.tol) begin
                        errors++;
                        $display("FAIL angle(%0d,%0d): got q=%0d theta=%0d at edge %0d, want q=%0d theta=%0d+/-%0d at edge %0d",
                                 e.x, e.y, quadrant, theta_1st_quad, cyc, e.q, e.th, e.tol, e.due);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d results outstanding", sb.size());
        $fatal(1, "timeout");
    end

    int dx[16] = '{1000, 1000, 0, 1000, -1000, 1000, -1732, -32768, 32767, 0, -1000, 0, -32768, 0, 32767, -32768};
    int dy[16] = '{0, 0, 1000, 1000, -1000, -1732, 1000, -32768, -32768, 0, 0, -1000, 0, -32768, 32767, 32767};

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        foreach (dx[i]) send(dx[i], dy[i]);

        for (int k = 0; k < 36; k++) begin
            real ang;
            ang = real'(k) * 10.0 * PI / 180.0;
            send($rtoi($floor(20000.0 * $cos(ang) + 0.5)), $rtoi($floor(20000.0 * $sin(ang) + 0.5)));
        end

        for (int k = 0; k < 150; k++) send_random();

        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        send(1000, -1732);
        for (int k = 0; k < 40; k++) send_random();
        send(0, 0);
        send(-1000, 0);

        repeat (12) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d results outstanding, want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
